noc_rx_dispatcher: RTL and testbench

Controller that sequences a `noc_serial_receiver` and shares its output between `N_DEST` local consumers. It waits for a completed packet from the receiver and uses the low header padding bits as the destination index. It queues the packet and destination in a small FIFO, then pulses `flush` to re-arm the receiver. The FIFO head goes to its destination over a per-consumer valid/ready handshake. The block sits between the receiver and the node's local engines.

---
 rtl/noc_rx_pkg.sv | 18 +
 rtl/noc_sync_fifo.sv | 64 ++++++
 rtl/noc_rx_dispatcher.sv | 122 ++++++++++++
 tb/tb_noc_rx_dispatcher.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_rx_pkg.sv
// ============================================================================
// noc_rx_pkg : shared FSM encoding and constants for the NoC receive dispatcher
// Revision   : 1.0
// ============================================================================
`default_nettype none

package noc_rx_pkg;

  localparam int DROP_CNT_W = 8;

  typedef enum logic [0:0] {
    WAIT  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/noc_sync_fifo.sv
// ============================================================================
// noc_sync_fifo : synchronous FIFO with level output, no push/pop bypass
// Revision      : 1.0
// ============================================================================
`default_nettype none

module noc_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by the level alone.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_rx_dispatcher.sv
// ============================================================================
// noc_rx_dispatcher : re-arms the serial receiver and routes queued packets
//                     to N_DEST consumers by the low padding bits
// Revision          : 1.0
// ============================================================================
`default_nettype none

module noc_rx_dispatcher
  import noc_rx_pkg::*;
#(
  parameter int PACKET_BITS  = 16,
  parameter int PADDING_BITS = 4,
  parameter int N_DEST       = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_valid,
  input  logic [PADDING_BITS-1:0]           rx_padding,
  input  logic [PACKET_BITS-1:0]            rx_packet,
  output logic                              flush,
  output logic [N_DEST-1:0]                 out_valid,
  input  logic [N_DEST-1:0]                 out_ready,
  output logic [PACKET_BITS-1:0]            out_packet,
  output logic [DROP_CNT_W-1:0]             drop_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int DEST_BITS = $clog2(N_DEST);
  localparam int FIFO_W    = DEST_BITS + PACKET_BITS;

  state_t                  r_state;
  logic                    r_flush;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [DEST_BITS-1:0]    w_dest;
  logic                    w_dest_ok;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [FIFO_W-1:0]       w_head;
  logic [DEST_BITS-1:0]    w_head_dest;

  assign w_dest    = rx_padding[DEST_BITS-1:0];
  assign w_dest_ok = ({1'b0, w_dest} < (DEST_BITS+1)'(N_DEST));

  generate
    if (PADDING_BITS > DEST_BITS) begin : g_pad_unused
      logic w_unused_pad;
      assign w_unused_pad = ^rx_padding[PADDING_BITS-1:DEST_BITS];
    end
  endgenerate

  // Push decision looks only at the registered full flag, so a pop that
  // frees a slot lets the held packet in on the following edge.
  assign w_push = (r_state == WAIT) && rx_valid && w_dest_ok && !w_full;
  assign w_pop  = |(out_valid & out_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= WAIT;
      r_flush    <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          r_flush <= 1'b0;
          if (rx_valid) begin
            if (!w_dest_ok) begin
              if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
              end
              r_state <= FLUSH;
              r_flush <= 1'b1;
            end else if (!w_full) begin
              r_state <= FLUSH;
              r_flush <= 1'b1;
            end
          end
        end
        FLUSH: begin
          r_flush <= 1'b0;
          r_state <= WAIT;
        end
        default: begin
          r_flush <= 1'b0;
          r_state <= WAIT;
        end
      endcase
    end
  end

  noc_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({w_dest, rx_packet}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign w_head_dest = w_head[FIFO_W-1:PACKET_BITS];
  assign out_packet  = w_empty ? '0 : w_head[PACKET_BITS-1:0];
  assign flush       = r_flush;
  assign drop_cnt    = r_drop_cnt;

  always_comb begin
    out_valid = '0;
    for (int d = 0; d < N_DEST; d++) begin
      out_valid[d] = !w_empty && (w_head_dest == DEST_BITS'(d));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_rx_dispatcher.sv
// ============================================================================
// tb_noc_rx_dispatcher : directed bench, one 4-consumer and one 3-consumer DUT
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_noc_rx_dispatcher;

  logic        clk = 1'b0;
  logic        rst;

  logic        rx_valid;
  logic [3:0]  rx_padding;
  logic [15:0] rx_packet;
  logic        flush;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_packet;
  logic [7:0]  drop_cnt;
  logic [2:0]  fifo_level;

  logic        b_rx_valid;
  logic [3:0]  b_rx_padding;
  logic [15:0] b_rx_packet;
  logic        b_flush;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [15:0] b_out_packet;
  logic [7:0]  b_drop_cnt;
  logic [2:0]  b_fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_rx_dispatcher #(
    .PACKET_BITS(16), .PADDING_BITS(4), .N_DEST(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_padding(rx_padding),
    .rx_packet(rx_packet), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_packet(out_packet), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  noc_rx_dispatcher #(
    .PACKET_BITS(16), .PADDING_BITS(4), .N_DEST(3), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_padding(b_rx_padding),
    .rx_packet(b_rx_packet), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_packet(b_out_packet), .drop_cnt(b_drop_cnt),
    .fifo_level(b_fifo_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0; rx_padding = '0; rx_packet = '0; out_ready = '0;
    b_rx_valid = 1'b0; b_rx_padding = '0; b_rx_packet = '0; b_out_ready = '0;
    tick();
    tick();
    check("rst_flush", flush, 0);
    check("rst_valid", out_valid, 0);
    check("rst_packet", out_packet, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_level", fifo_level, 0);
    check("rst_b_drop", b_drop_cnt, 0);
    rst = 1'b1;
    tick();

    // single packet to dest 2; rx_valid held through the flush edge
    out_ready = 4'hF; rx_padding = 4'h2; rx_packet = 16'hBEEF; rx_valid = 1'b1;
    tick();
    check("single_flush", flush, 1);
    check("single_valid", out_valid, 4'b0100);
    check("single_packet", out_packet, 16'hBEEF);
    check("single_level", fifo_level, 1);
    tick();
    rx_valid = 1'b0;
    check("single_flush_end", flush, 0);
    check("single_valid_end", out_valid, 0);
    check("single_no_repush", fifo_level, 0);

    // invalid destination on the 3-consumer instance
    b_out_ready = 3'b111; b_rx_padding = 4'h3; b_rx_packet = 16'hDEAD; b_rx_valid = 1'b1;
    tick();
    b_rx_valid = 1'b0;
    check("drop_flush", b_flush, 1);
    check("drop_cnt1", b_drop_cnt, 1);
    check("drop_level", b_fifo_level, 0);
    check("drop_valid", b_out_valid, 0);
    tick();
    check("drop_flush_end", b_flush, 0);
    for (int i = 0; i < 299; i++) begin
      b_rx_valid = 1'b1;
      tick();
      b_rx_valid = 1'b0;
      tick();
    end
    check("drop_saturate", b_drop_cnt, 255);

    // upper padding bits ignored: 4'h6 -> dest 2
    b_rx_padding = 4'h6; b_rx_packet = 16'h6262; b_rx_valid = 1'b1;
    tick();
    b_rx_valid = 1'b0;
    check("pad_hi_valid", b_out_valid, 3'b100);
    check("pad_hi_packet", b_out_packet, 16'h6262);
    check("pad_hi_drop", b_drop_cnt, 255);
    tick();
    check("pad_hi_popped", b_fifo_level, 0);

    // back-pressure fill to dest 1
    out_ready = 4'h0; rx_padding = 4'h1;
    for (int i = 0; i < 4; i++) begin
      rx_packet = 16'h1000 + 16'(i); rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
    end
    check("fill_level", fifo_level, 4);
    check("fill_head", out_packet, 16'h1000);
    rx_packet = 16'h1004; rx_valid = 1'b1;
    tick();
    check("full_no_flush_a", flush, 0);
    check("full_level_a", fifo_level, 4);
    tick();
    check("full_no_flush_b", flush, 0);
    out_ready = 4'b0010;
    tick();
    out_ready = 4'h0;
    check("pop_no_flush", flush, 0);
    check("pop_level", fifo_level, 3);
    check("pop_head", out_packet, 16'h1001);
    tick();
    rx_valid = 1'b0;
    check("late_push_flush", flush, 1);
    check("late_push_level", fifo_level, 4);
    tick();
    check("late_flush_end", flush, 0);
    out_ready = 4'b0010;
    for (int i = 1; i < 5; i++) begin
      check("drain_valid", out_valid, 4'b0010);
      check("drain_packet", out_packet, 16'h1000 + 16'(i));
      tick();
    end
    check("drain_level", fifo_level, 0);
    check("drain_valid_end", out_valid, 0);

    // head-of-line: A->dest0 blocks B->dest1
    rx_padding = 4'h0; rx_packet = 16'hAAAA; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    rx_padding = 4'h1; rx_packet = 16'hBBBB; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    check("hol_valid", out_valid, 4'b0001);
    check("hol_packet", out_packet, 16'hAAAA);
    check("hol_level", fifo_level, 2);
    out_ready = 4'b0011;
    tick();
    check("hol_b_valid", out_valid, 4'b0010);
    check("hol_b_packet", out_packet, 16'hBBBB);
    tick();
    check("hol_empty", fifo_level, 0);

    // simultaneous push and pop at level 2
    out_ready = 4'h0; rx_padding = 4'h3;
    for (int i = 1; i < 3; i++) begin
      rx_packet = 16'hC000 + 16'(i); rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
    end
    check("pp_level_pre", fifo_level, 2);
    rx_packet = 16'hC003; rx_valid = 1'b1; out_ready = 4'b1000;
    tick();
    rx_valid = 1'b0; out_ready = 4'h0;
    check("pp_level", fifo_level, 2);
    check("pp_head", out_packet, 16'hC002);
    check("pp_flush", flush, 1);
    tick();
    out_ready = 4'b1000;
    tick();
    check("pp_order", out_packet, 16'hC003);
    tick();
    check("pp_empty", fifo_level, 0);

    // reset during FLUSH with three entries queued
    out_ready = 4'h0; rx_padding = 4'h0;
    for (int i = 1; i < 4; i++) begin
      rx_packet = 16'hD000 + 16'(i); rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (i < 3) tick();
    end
    check("mid_flush", flush, 1);
    check("mid_level", fifo_level, 3);
    rst = 1'b0;
    tick();
    check("mrst_flush", flush, 0);
    check("mrst_level", fifo_level, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_packet", out_packet, 0);
    check("mrst_b_drop", b_drop_cnt, 0);
    rst = 1'b1;
    tick();
    out_ready = 4'hF; rx_padding = 4'h2; rx_packet = 16'h5A5A; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("post_flush", flush, 1);
    check("post_valid", out_valid, 4'b0100);
    check("post_packet", out_packet, 16'h5A5A);
    tick();
    check("post_level", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
